// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI engine arbiter.
//   - FSM state encoding (exposed on the arbiter's dbg_state output)
//   - cs_idx_w(): width of one chip-select index for a given NUM_CS
package spi_arb_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_BUSY  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  // A single chip select still needs a 1-bit index field on the port.
  function automatic int cs_idx_w(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_arbiter_rr_pick2.sv
// rr_pick2: two-way priority pick.
//   valid[1:0] : requests
//   prio       : index preferred when both request
//   grant      : winning index (meaningful only when any=1)
//   any        : at least one request present
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any = |valid;
    if (&valid) grant = prio;
    else        grant = valid[1];
  end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one byte-wide SPI engine between two requesters
// (0 = memory controller, 1 = register-space peripheral). A requester is
// granted a whole burst, ended by a byte flagged req_last. The arbiter drives
// the chip selects, enforces CS setup and hold gaps, and returns every RX
// byte to the burst owner.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req_valid[i]    requester i offers a TX byte
//   req_ready[i]    arbiter accepts requester i's byte (combinational)
//   req_data        [8i+7:8i] = requester i TX byte
//   req_last[i]     byte closes the burst, CS released afterwards
//   req_cs          per-requester CS index, used on a burst's first byte only
//   rsp_valid[i]    one-cycle pulse: rsp_data belongs to requester i
//   rsp_data        received byte
//   spi_data_tx     byte to the SPI engine, stable during the exchange
//   spi_txn_start   one-cycle pulse starting an exchange
//   spi_data_rx     byte from the SPI engine, valid with spi_txn_done
//   spi_txn_done    one-cycle pulse: exchange complete
//   cs_n            active-low chip selects, registered
//   dbg_state       current FSM state (spi_arb_pkg ST_* encoding)
//
// Handshake: a byte moves on a rising clk edge where req_valid[i] and
// req_ready[i] are both high. req_ready never depends on req_valid, and a
// requester must hold its byte, last flag and CS index stable while valid
// is high and ready is low.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_CS          = 2,
  parameter int CS_SETUP_CYCLES = 1,
  parameter int CS_HOLD_CYCLES  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [15:0]                   req_data,
  input  logic [1:0]                    req_last,
  input  logic [2*cs_idx_w(NUM_CS)-1:0] req_cs,
  output logic [1:0]                    rsp_valid,
  output logic [7:0]                    rsp_data,
  output logic [7:0]                    spi_data_tx,
  output logic                          spi_txn_start,
  input  logic [7:0]                    spi_data_rx,
  input  logic                          spi_txn_done,
  output logic [NUM_CS-1:0]             cs_n,
  output logic [2:0]                    dbg_state
);

  localparam int CSW     = cs_idx_w(NUM_CS);
  localparam int HOLD_N  = (CS_HOLD_CYCLES < 1) ? 1 : CS_HOLD_CYCLES;
  localparam int CNT_MAX = (CS_SETUP_CYCLES > HOLD_N) ? CS_SETUP_CYCLES : HOLD_N;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST =
    (CS_SETUP_CYCLES > 0) ? CNT_W'(CS_SETUP_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_N - 1);

  logic [2:0]        state;
  logic              owner;
  logic              prio;
  logic              last_q;
  logic [CNT_W-1:0]  cnt;

  logic              win;
  logic              any;
  logic [CSW-1:0]    win_cs;
  logic [NUM_CS-1:0] cs_mask;
  logic              xfer;
  logic [7:0]        owner_data;
  logic              owner_last;

  rr_pick2 u_pick (
    .valid (req_valid),
    .prio  (prio),
    .grant (win),
    .any   (any)
  );

  // Chip select for the winner; an index beyond NUM_CS falls back to CS 0.
  always_comb begin
    win_cs  = win ? req_cs[2*CSW-1:CSW] : req_cs[CSW-1:0];
    cs_mask = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(win_cs) == i) cs_mask[i] = 1'b1;
    end
    if (cs_mask == '0) cs_mask[0] = 1'b1;
  end

  assign req_ready[0] = (state == ST_ISSUE) && !owner;
  assign req_ready[1] = (state == ST_ISSUE) &&  owner;

  assign owner_data = owner ? req_data[15:8] : req_data[7:0];
  assign owner_last = owner ? req_last[1]    : req_last[0];
  assign xfer       = (state == ST_ISSUE) && (owner ? req_valid[1] : req_valid[0]);

  assign dbg_state = state;

  // cnt is shared: it times the CS setup gap and the CS hold gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      owner         <= 1'b0;
      prio          <= 1'b0;
      last_q        <= 1'b0;
      cnt           <= '0;
      cs_n          <= '1;
      spi_txn_start <= 1'b0;
      spi_data_tx   <= 8'h00;
      rsp_valid     <= 2'b00;
      rsp_data      <= 8'h00;
    end else begin
      spi_txn_start <= 1'b0;
      rsp_valid     <= 2'b00;
      case (state)
        ST_IDLE: begin
          // Grant only; the first byte is consumed later in ISSUE.
          if (any) begin
            owner <= win;
            cs_n  <= ~cs_mask;
            cnt   <= '0;
            state <= (CS_SETUP_CYCLES == 0) ? ST_ISSUE : ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == SETUP_LAST) state <= ST_ISSUE;
          else                   cnt   <= cnt + 1'b1;
        end
        ST_ISSUE: begin
          if (xfer) begin
            spi_data_tx   <= owner_data;
            spi_txn_start <= 1'b1;
            last_q        <= owner_last;
            state         <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (spi_txn_done) begin
            rsp_data         <= spi_data_rx;
            rsp_valid[owner] <= 1'b1;
            cnt              <= '0;
            if (last_q) begin
              cs_n  <= '1;
              prio  <= ~owner;
              state <= ST_HOLD;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) state <= ST_IDLE;
          else                  cnt   <= cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Testbench for spi_arbiter. The main instance uses CS_SETUP_CYCLES=1 and
// CS_HOLD_CYCLES=3 with an echoing SPI engine model (rx = ~tx after a random
// delay); a second instance with CS_SETUP_CYCLES=0 is driven by hand.
module tb_spi_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  logic [1:0]  req_valid, req_ready, req_last, req_cs, rsp_valid, cs_n;
  logic [15:0] req_data;
  logic [7:0]  rsp_data, spi_data_tx, spi_data_rx;
  logic        spi_txn_start, spi_txn_done;
  logic [2:0]  dbg_state;

  spi_arbiter #(.NUM_CS(2), .CS_SETUP_CYCLES(1), .CS_HOLD_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_last(req_last), .req_cs(req_cs),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .spi_data_tx(spi_data_tx), .spi_txn_start(spi_txn_start),
    .spi_data_rx(spi_data_rx), .spi_txn_done(spi_txn_done),
    .cs_n(cs_n), .dbg_state(dbg_state)
  );

  // ---------------- zero-setup instance ----------------
  logic [1:0]  z_req_valid, z_req_ready, z_req_last, z_req_cs, z_rsp_valid, z_cs_n;
  logic [15:0] z_req_data;
  logic [7:0]  z_rsp_data, z_spi_data_tx, z_spi_data_rx;
  logic        z_spi_txn_start, z_spi_txn_done;
  logic [2:0]  z_dbg_state;

  spi_arbiter #(.NUM_CS(2), .CS_SETUP_CYCLES(0), .CS_HOLD_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_data(z_req_data),
    .req_last(z_req_last), .req_cs(z_req_cs),
    .rsp_valid(z_rsp_valid), .rsp_data(z_rsp_data),
    .spi_data_tx(z_spi_data_tx), .spi_txn_start(z_spi_txn_start),
    .spi_data_rx(z_spi_data_rx), .spi_txn_done(z_spi_txn_done),
    .cs_n(z_cs_n), .dbg_state(z_dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int          checks = 0;
  int          errors = 0;
  logic [9:0]  exp_q[$];      // {rsp_valid one-hot, rsp_data}
  int          grant_log[$];  // requester index of each accepted byte
  bit          core_en = 1'b1;
  int          core_lat;
  logic [9:0]  mon_exp;
  logic [1:0]  cs_prev = 2'b11;
  bit          in_flight = 1'b0;

  // ---------------- SPI engine model ----------------
  // Drives spi_txn_done/spi_data_rx just after a rising edge.
  always begin
    @(negedge clk);
    if (spi_txn_start && core_en && !rst) begin
      core_lat = $urandom_range(1, 4);
      repeat (core_lat) @(posedge clk);
      #1;
      if (core_en && !rst) begin
        spi_data_rx  = ~spi_data_tx;
        spi_txn_done = 1'b1;
        @(posedge clk);
        #1 spi_txn_done = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / invariant monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      in_flight = 1'b0;
    end else begin
      checks++;
      if (cs_n == 2'b00) begin
        errors++;
        $display("FAIL cs_onehot: cs_n=%b, required at most one low", cs_n);
      end
      checks++;
      if (in_flight && cs_n !== cs_prev) begin
        errors++;
        $display("FAIL cs_stable_busy: cs_n=%b, required %b", cs_n, cs_prev);
      end
      if (spi_txn_start) in_flight = 1'b1;
      if (spi_txn_done)  in_flight = 1'b0;
      if (rsp_valid !== 2'b00) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b rsp_data=%h, required no response", rsp_valid, rsp_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({rsp_valid, rsp_data} !== mon_exp) begin
            errors++;
            $display("FAIL rsp: got valid=%b data=%h, required valid=%b data=%h",
                     rsp_valid, rsp_data, mon_exp[9:8], mon_exp[7:0]);
          end
        end
      end
    end
    cs_prev = cs_n;
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input int who, input logic [7:0] d, input logic last, input logic cs);
    int         t;
    logic [1:0] exp_csn, onehot;
    exp_csn = cs ? 2'b01 : 2'b10;
    onehot  = (who == 1) ? 2'b10 : 2'b01;
    req_valid[who]       = 1'b1;
    req_data[who*8 +: 8] = d;
    req_last[who]        = last;
    req_cs[who]          = cs;
    t = 0;
    while (req_ready[who] !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 300) begin
      errors++;
      $display("FAIL ready_timeout: requester %0d ready=%b after %0d cycles, required 1", who, req_ready[who], t);
    end else begin
      exp_q.push_back({onehot, ~d});
      grant_log.push_back(who);
      checks++;
      if (cs_n !== exp_csn) begin
        errors++;
        $display("FAIL cs_during_burst: cs_n=%b, required %b", cs_n, exp_csn);
      end
      checks++;
      if (req_ready[1-who] !== 1'b0) begin
        errors++;
        $display("FAIL other_ready: requester %0d ready=%b, required 0", 1-who, req_ready[1-who]);
      end
    end
    @(negedge clk);
    req_valid[who] = 1'b0;
  endtask

  task automatic burst(input int who, input int n, input logic cs);
    for (int i = 0; i < n; i++)
      send_byte(who, 8'($urandom_range(0, 255)), (i == n - 1), cs);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (cs_n !== 2'b11)          begin errors++; $display("FAIL reset_cs_n: got %b required 11", cs_n); end
    checks++; if (spi_txn_start !== 1'b0)  begin errors++; $display("FAIL reset_txn_start: got %b required 0", spi_txn_start); end
    checks++; if (spi_data_tx !== 8'h00)   begin errors++; $display("FAIL reset_data_tx: got %h required 00", spi_data_tx); end
    checks++; if (rsp_valid !== 2'b00)     begin errors++; $display("FAIL reset_rsp_valid: got %b required 00", rsp_valid); end
    checks++; if (rsp_data !== 8'h00)      begin errors++; $display("FAIL reset_rsp_data: got %h required 00", rsp_data); end
    checks++; if (req_ready !== 2'b00)     begin errors++; $display("FAIL reset_req_ready: got %b required 00", req_ready); end
    checks++; if (dbg_state !== spi_arb_pkg::ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", dbg_state, spi_arb_pkg::ST_IDLE); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 2'b00)     begin errors++; $display("FAIL idle_req_ready: got %b required 00", req_ready); end
  endtask

  // req0 burst A5,0F,3C on CS0, including the grant/setup/issue latency.
  task automatic test_single_burst();
    grant_log.delete();
    req_valid[0] = 1'b1; req_data[7:0] = 8'hA5; req_last[0] = 1'b0; req_cs[0] = 1'b0;
    @(negedge clk);
    checks++; if (cs_n !== 2'b10)      begin errors++; $display("FAIL lat_cs_low: got %b required 10", cs_n); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL lat_setup_ready: got %b required 00", req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL lat_ready: got %b required 01", req_ready); end
    exp_q.push_back({2'b01, 8'h5A});
    grant_log.push_back(0);
    @(negedge clk);
    checks++; if (spi_txn_start !== 1'b1) begin errors++; $display("FAIL lat_txn_start: got %b required 1", spi_txn_start); end
    checks++; if (spi_data_tx !== 8'hA5)  begin errors++; $display("FAIL lat_data_tx: got %h required A5", spi_data_tx); end
    send_byte(0, 8'h0F, 1'b0, 1'b0);
    send_byte(0, 8'h3C, 1'b1, 1'b0);
    wait_drain();
    checks++; if (cs_n !== 2'b11) begin errors++; $display("FAIL burst_cs_release: got %b required 11", cs_n); end
    checks++; if (grant_log.size() != 3) begin errors++; $display("FAIL burst_count: got %0d required 3", grant_log.size()); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_contention();
    int exp_g[6] = '{0, 0, 1, 1, 0, 0};
    do_reset();
    grant_log.delete();
    fork
      begin burst(0, 2, 1'b0); burst(0, 2, 1'b0); end
      begin burst(1, 2, 1'b1); end
    join
    wait_drain();
    checks++;
    if (grant_log.size() != 6) begin
      errors++; $display("FAIL contention_count: got %0d required 6", grant_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (grant_log[i] != exp_g[i]) begin
          errors++; $display("FAIL contention_order[%0d]: got %0d required %0d", i, grant_log[i], exp_g[i]);
        end
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_block();
    int exp_g[4] = '{1, 1, 1, 0};
    int hi;
    int t;
    grant_log.delete();
    hi = 0;
    fork
      burst(1, 3, 1'b1);
      begin repeat (4) @(negedge clk); send_byte(0, 8'h81, 1'b1, 1'b0); end
      begin
        t = 0;
        while (grant_log.size() < 3 && t < 300) begin @(negedge clk); t++; end
        t = 0;
        while (cs_n !== 2'b11 && t < 300) begin @(negedge clk); t++; end
        while (cs_n === 2'b11 && hi < 50) begin @(negedge clk); hi++; end
      end
    join
    wait_drain();
    // HOLD (3 cycles) plus the IDLE grant cycle
    checks++; if (hi != 4) begin errors++; $display("FAIL hold_gap: cs_n high %0d cycles, required 4", hi); end
    checks++;
    if (grant_log.size() != 4) begin
      errors++; $display("FAIL block_count: got %0d required 4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grant_log[i] != exp_g[i]) begin
          errors++; $display("FAIL block_order[%0d]: got %0d required %0d", i, grant_log[i], exp_g[i]);
        end
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_stall();
    send_byte(0, 8'h12, 1'b0, 1'b0);
    wait_drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (spi_txn_start !== 1'b0 || cs_n !== 2'b10 || req_ready !== 2'b01) begin
        errors++;
        $display("FAIL stall[%0d]: start=%b cs_n=%b ready=%b, required 0/10/01", i, spi_txn_start, cs_n, req_ready);
      end
    end
    send_byte(0, 8'hE7, 1'b1, 1'b0);
    wait_drain();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_busy();
    core_en = 1'b0;
    send_byte(0, 8'h44, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (cs_n !== 2'b11)         begin errors++; $display("FAIL rst_busy_cs_n: got %b required 11", cs_n); end
    checks++; if (rsp_valid !== 2'b00)    begin errors++; $display("FAIL rst_busy_rsp: got %b required 00", rsp_valid); end
    checks++; if (spi_txn_start !== 1'b0) begin errors++; $display("FAIL rst_busy_start: got %b required 0", spi_txn_start); end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    core_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_dropped[%0d]: rsp_valid=%b required 00", i, rsp_valid); end
    end
    send_byte(1, 8'hB2, 1'b1, 1'b1);
    wait_drain();
    repeat (6) @(negedge clk);
    checks++; if (cs_n !== 2'b11) begin errors++; $display("FAIL post_rst_release: got %b required 11", cs_n); end
  endtask

  task automatic test_setup0();
    @(negedge clk);
    z_req_valid = 2'b01; z_req_data[7:0] = 8'h33; z_req_last = 2'b00; z_req_cs = 2'b00;
    @(negedge clk);
    checks++; if (z_cs_n !== 2'b10)      begin errors++; $display("FAIL z_cs_low: got %b required 10", z_cs_n); end
    checks++; if (z_req_ready !== 2'b01) begin errors++; $display("FAIL z_ready: got %b required 01", z_req_ready); end
    @(negedge clk);
    checks++; if (z_spi_txn_start !== 1'b1) begin errors++; $display("FAIL z_start: got %b required 1", z_spi_txn_start); end
    checks++; if (z_spi_data_tx !== 8'h33)  begin errors++; $display("FAIL z_data_tx: got %h required 33", z_spi_data_tx); end
    z_req_valid = 2'b00;
    z_spi_data_rx = 8'hCC; z_spi_txn_done = 1'b1;
    @(negedge clk);
    checks++; if (z_rsp_valid !== 2'b01) begin errors++; $display("FAIL z_rsp_valid: got %b required 01", z_rsp_valid); end
    checks++; if (z_rsp_data !== 8'hCC)  begin errors++; $display("FAIL z_rsp_data: got %h required CC", z_rsp_data); end
    // stray completion while waiting in ISSUE
    z_spi_data_rx = 8'hEE; z_spi_txn_done = 1'b1;
    @(negedge clk);
    z_spi_txn_done = 1'b0;
    checks++; if (z_rsp_valid !== 2'b00) begin errors++; $display("FAIL z_stray_rsp: got %b required 00", z_rsp_valid); end
    checks++; if (z_rsp_data !== 8'hCC)  begin errors++; $display("FAIL z_stray_data: got %h required CC", z_rsp_data); end
    checks++; if (z_req_ready !== 2'b01) begin errors++; $display("FAIL z_stray_ready: got %b required 01", z_req_ready); end
    z_req_valid = 2'b01; z_req_data[7:0] = 8'h96; z_req_last = 2'b01;
    @(negedge clk);
    checks++; if (z_spi_txn_start !== 1'b1 || z_spi_data_tx !== 8'h96) begin
      errors++; $display("FAIL z_start2: start=%b data=%h, required 1/96", z_spi_txn_start, z_spi_data_tx);
    end
    z_req_valid = 2'b00;
    z_spi_data_rx = 8'h69; z_spi_txn_done = 1'b1;
    @(negedge clk);
    z_spi_txn_done = 1'b0;
    checks++; if (z_rsp_valid !== 2'b01 || z_rsp_data !== 8'h69) begin
      errors++; $display("FAIL z_rsp2: valid=%b data=%h, required 01/69", z_rsp_valid, z_rsp_data);
    end
    checks++; if (z_cs_n !== 2'b11) begin errors++; $display("FAIL z_cs_release: got %b required 11", z_cs_n); end
    @(negedge clk);
    checks++; if (z_cs_n !== 2'b11) begin errors++; $display("FAIL z_hold: got %b required 11", z_cs_n); end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    req_valid = 2'b00; req_data = 16'h0; req_last = 2'b00; req_cs = 2'b00;
    spi_data_rx = 8'h00; spi_txn_done = 1'b0;
    z_req_valid = 2'b00; z_req_data = 16'h0; z_req_last = 2'b00; z_req_cs = 2'b00;
    z_spi_data_rx = 8'h00; z_spi_txn_done = 1'b0;
    test_reset();
    test_single_burst();
    test_contention();
    test_block();
    test_stall();
    test_reset_busy();
    test_setup0();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover: %0d responses never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
